// File: rtl/ws2812_frame_sequencer_pkg.sv
// ws2812_frame_sequencer_pkg: shared FSM encoding, mux widths and index sizing
package ws2812_frame_sequencer_pkg;
   localparam int SEL_WIDTH = 2;
   localparam int WIDTH_MUX = 24;
   typedef enum logic [2:0] {IDLE, SEND, DRAIN, LATCH, DONE} state_t;
   function automatic int idx_width(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/ws2812_frame_sequencer_if.sv
// ws2812_frame_sequencer_if: control, pixel handshake and status signals of the sequencer
interface ws2812_frame_sequencer_if #(parameter int NUM_LEDS = 8);
   import ws2812_frame_sequencer_pkg::*;
   logic i_start, i_continuous, i_rotate, i_abort, i_pix_ready, i_ser_busy;
   logic [SEL_WIDTH-1:0] o_sel;
   logic o_pix_valid;
   logic [idx_width(NUM_LEDS)-1:0] o_led_idx;
   logic o_latch, o_frame_done, o_busy;
   modport master (
      input  i_start, i_continuous, i_rotate, i_abort, i_pix_ready, i_ser_busy,
      output o_sel, o_pix_valid, o_led_idx, o_latch, o_frame_done, o_busy
   );
   modport slave (
      output i_start, i_continuous, i_rotate, i_abort, i_pix_ready, i_ser_busy,
      input  o_sel, o_pix_valid, o_led_idx, o_latch, o_frame_done, o_busy
   );
endinterface

// File: rtl/ws2812_latch_timer.sv
// ws2812_latch_timer: counts line-reset clocks; expired marks the last cycle of the period
module ws2812_latch_timer #(parameter int RESET_CYCLES = 5000) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic count,
   output logic expired
);
   localparam int CW = $clog2(RESET_CYCLES);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (start) cnt <= '0;
      else if (count && !expired) cnt <= cnt + 1'b1;
   assign expired = cnt == CW'(RESET_CYCLES - 1);
endmodule

// File: rtl/ws2812_frame_sequencer.sv
// ws2812_frame_sequencer: walks NUM_LEDS pixels through a 4:1 colour mux, then drains and latches the line
module ws2812_frame_sequencer import ws2812_frame_sequencer_pkg::*; #(
   parameter int NUM_LEDS     = 8,
   parameter int RESET_CYCLES = 5000
) (
   input logic i_clk,
   input logic i_rst,
   ws2812_frame_sequencer_if.master bus
);
   localparam int IW = idx_width(NUM_LEDS);
   localparam logic [IW-1:0] LAST = IW'(NUM_LEDS - 1);
   state_t state;
   logic [IW-1:0] idx;
   logic [SEL_WIDTH-1:0] offset;
   logic aborted, expired;
   ws2812_latch_timer #(.RESET_CYCLES(RESET_CYCLES)) u_timer (
      .clk(i_clk),
      .rst(i_rst),
      .start(state == DRAIN && !bus.i_ser_busy),
      .count(state == LATCH),
      .expired(expired)
   );
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         state   <= IDLE;
         idx     <= '0;
         offset  <= '0;
         aborted <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.i_start) begin
               idx     <= '0;
               aborted <= 1'b0;
               state   <= SEND;
            end
            SEND: begin
               if (bus.i_pix_ready && idx != LAST) idx <= idx + 1'b1;
               if (bus.i_abort) aborted <= 1'b1;
               if (bus.i_abort || (bus.i_pix_ready && idx == LAST)) state <= DRAIN;
            end
            DRAIN: if (!bus.i_ser_busy) state <= LATCH;
            LATCH: if (expired) state <= DONE;
            DONE: begin
               // an aborted frame keeps the colour offset and never auto-restarts
               if (bus.i_rotate && !aborted) offset <= offset + 1'b1;
               if (bus.i_continuous && !aborted) idx <= '0;
               state <= (bus.i_continuous && !aborted) ? SEND : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   assign bus.o_pix_valid  = state == SEND;
   assign bus.o_sel        = state == SEND ? SEL_WIDTH'(idx) + offset : '0;
   assign bus.o_led_idx    = idx;
   assign bus.o_latch      = state == LATCH;
   assign bus.o_frame_done = state == DONE;
   assign bus.o_busy       = state != IDLE;
endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// tb_ws2812_frame_sequencer: randomized frames checked against a frame-level model of the sequencer
module tb_ws2812_frame_sequencer;
   localparam int N  = 8;
   localparam int RC = 5000;
   logic clk = 1'b0;
   logic rst;
   int total = 0;
   int bad = 0;
   int off = 0;
   ws2812_frame_sequencer_if #(.NUM_LEDS(N)) bus ();
   ws2812_frame_sequencer #(.NUM_LEDS(N), .RESET_CYCLES(RC)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   initial begin
      #1ms;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask
   task automatic start_frame();
      check("idle_busy", bus.o_busy, 0);
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      check("start_valid", bus.o_pix_valid, 1);
   endtask
   // Runs one frame from its first SEND cycle through DONE; ab<0 means no abort.
   task automatic frame(input int ab, input int hold, input bit rnd, input bit rot, input bit cont);
      int k = 0;
      int lat = 0;
      int g = 0;
      bit ev = 1'b1;
      bit cut;
      bit go;
      while (ev && g < 400) begin
         check("sel", bus.o_sel, (k + off) % 4);
         check("idx", bus.o_led_idx, k);
         bus.i_pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.i_abort = (k == ab);
         cut = bus.i_abort;
         tick();
         if (bus.i_pix_ready) k++;
         ev = !cut && k < N;
         check("valid", bus.o_pix_valid, int'(ev));
         g++;
      end
      bus.i_pix_ready = 1'b0;
      bus.i_abort = 1'b0;
      for (int i = 0; i < hold; i++) begin
         bus.i_ser_busy = 1'b1;
         check("drain_latch", bus.o_latch, 0);
         check("drain_busy", bus.o_busy, 1);
         tick();
      end
      bus.i_ser_busy = 1'b0;
      check("drain_end", bus.o_latch, 0);
      tick();
      while (bus.o_latch && lat < RC + 5) begin
         lat++;
         bus.i_abort = 1'($urandom_range(0, 1));
         bus.i_start = 1'($urandom_range(0, 1));
         tick();
      end
      bus.i_abort = 1'b0;
      bus.i_start = 1'b0;
      check("latch_len", lat, RC);
      check("done", bus.o_frame_done, 1);
      check("done_busy", bus.o_busy, 1);
      bus.i_rotate = rot;
      bus.i_continuous = cont;
      tick();
      go = cont && ab < 0;
      if (rot && ab < 0) off = (off + 1) % 4;
      check("done_once", bus.o_frame_done, 0);
      check("restart", bus.o_pix_valid, int'(go));
      check("busy_after", bus.o_busy, int'(go));
      bus.i_rotate = 1'b0;
      bus.i_continuous = 1'b0;
   endtask
   initial begin
      int g;
      rst = 1'b1;
      bus.i_start = 1'b0;
      bus.i_continuous = 1'b0;
      bus.i_rotate = 1'b0;
      bus.i_abort = 1'b0;
      bus.i_pix_ready = 1'b0;
      bus.i_ser_busy = 1'b0;
      repeat (3) tick();
      check("rst_sel", bus.o_sel, 0);
      check("rst_valid", bus.o_pix_valid, 0);
      check("rst_idx", bus.o_led_idx, 0);
      check("rst_latch", bus.o_latch, 0);
      check("rst_done", bus.o_frame_done, 0);
      check("rst_busy", bus.o_busy, 0);
      rst = 1'b0;
      bus.i_continuous = 1'b1;
      bus.i_pix_ready = 1'b1;
      repeat (5) tick();
      check("no_start_busy", bus.o_busy, 0);
      check("no_start_valid", bus.o_pix_valid, 0);
      bus.i_continuous = 1'b0;
      bus.i_pix_ready = 1'b0;
      start_frame();
      frame(-1, 20, 1'b0, 1'b0, 1'b0);
      start_frame();
      frame(-1, 0, 1'b1, 1'b0, 1'b0);
      start_frame();
      for (int f = 0; f < 5; f++) frame(-1, 0, 1'b0, 1'b1, f < 4);
      start_frame();
      frame(3, 2, 1'b0, 1'b1, 1'b1);
      repeat (2) begin
         start_frame();
         frame($urandom_range(0, 1) ? -1 : int'($urandom_range(0, N - 1)),
               int'($urandom_range(0, 5)), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      end
      start_frame();
      bus.i_pix_ready = 1'b1;
      g = 0;
      while (bus.o_pix_valid && g < 50) begin
         tick();
         g++;
      end
      check("partial_len", g, N);
      bus.i_pix_ready = 1'b0;
      tick();
      repeat (100) tick();
      check("in_latch", bus.o_latch, 1);
      #2 rst = 1'b1;
      #1;
      off = 0;
      check("arst_sel", bus.o_sel, 0);
      check("arst_valid", bus.o_pix_valid, 0);
      check("arst_idx", bus.o_led_idx, 0);
      check("arst_latch", bus.o_latch, 0);
      check("arst_done", bus.o_frame_done, 0);
      check("arst_busy", bus.o_busy, 0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check("post_rst_done", bus.o_frame_done, 0);
      start_frame();
      frame(-1, 0, 1'b1, 1'b1, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ws2812_frame_sequencer.md
WS2812_FRAME_SEQUENCER -- requirements
Module: ws2812_frame_sequencer

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8; number of pixels per frame, legal range 1..1024.
REQ-002 SHALL have parameter RESET_CYCLES, default 5000; latch/reset low time in clocks (50 us at 100 MHz), minimum 2.
REQ-003 SHALL have port i_clk, input, 1 bit; the single clock.
REQ-004 SHALL have port i_rst, input, 1 bit; asynchronous, active-high reset.
REQ-005 SHALL have port i_start, input, 1 bit; frame start request, sampled only in IDLE.
REQ-006 SHALL have port i_continuous, input, 1 bit; when 1, the block restarts frames back-to-back with no further i_start.
REQ-007 SHALL have port i_rotate, input, 1 bit; when 1, the colour offset advances by one per completed frame.
REQ-008 SHALL have port i_abort, input, 1 bit; terminates the current frame.
REQ-009 SHALL have port i_pix_ready, input, 1 bit; the serializer accepts the current 24-bit pixel.
REQ-010 SHALL have port i_ser_busy, input, 1 bit; the serializer is still shifting bits.
REQ-011 SHALL have port o_sel, output, 2 bits; select for the 4:1 24-bit colour mux.
REQ-012 SHALL have port o_pix_valid, output, 1 bit; the mux output is a valid pixel.
REQ-013 SHALL have port o_led_idx, output, clog2(NUM_LEDS) bits; index of the current pixel.
REQ-014 SHALL have port o_latch, output, 1 bit; high during the line-reset period, so the data line is held low.
REQ-015 SHALL have port o_frame_done, output, 1 bit; one-cycle pulse at frame completion.
REQ-016 SHALL have port o_busy, output, 1 bit; high in every state except IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, SEND, DRAIN, LATCH and DONE.
REQ-018 In IDLE, i_start=1 SHALL set led_idx=0 and move the FSM to SEND on the next edge.
REQ-019 In SEND, o_pix_valid SHALL be 1 and o_sel SHALL equal (led_idx + offset) mod 4, where the 2-bit addition wraps.
REQ-020 A transfer SHALL occur when o_pix_valid and i_pix_ready are both 1; o_sel and o_led_idx SHALL stay stable until that transfer.
REQ-021 On a transfer with led_idx<NUM_LEDS-1, led_idx SHALL increment by 1 and the FSM SHALL stay in SEND; back-to-back transfers at one pixel per cycle SHALL be supported.
REQ-022 On a transfer with led_idx==NUM_LEDS-1, the FSM SHALL go to DRAIN; o_pix_valid SHALL be 0 in the next cycle.
REQ-023 In DRAIN, i_ser_busy=0 SHALL move the FSM to LATCH and clear the latch counter.
REQ-024 In LATCH, o_latch SHALL be 1 for exactly RESET_CYCLES cycles, after which the FSM SHALL go to DONE.
REQ-025 In DONE, o_frame_done SHALL be 1 for exactly one cycle.
REQ-026 In DONE with i_rotate=1, offset SHALL advance by 1 mod 4 (3 wraps to 0).
REQ-027 Leaving DONE, i_continuous=1 SHALL move the FSM to SEND with led_idx=0; otherwise the FSM SHALL go to IDLE.
REQ-028 i_abort=1 in SEND SHALL force DRAIN next cycle and drop o_pix_valid, so the line is always reset after a partial frame; an abort in the same cycle as a transfer SHALL take priority, with the pixel counted as sent.
REQ-029 i_abort SHALL be ignored in IDLE, DRAIN, LATCH and DONE.
REQ-030 An i_abort-terminated frame SHALL still produce o_frame_done, SHALL NOT advance offset, and SHALL return the FSM to IDLE regardless of i_continuous.
REQ-031 i_start SHALL be ignored outside IDLE.
REQ-032 With NUM_LEDS=1, the first transfer SHALL go directly to DRAIN.

Reset
REQ-033 i_rst SHALL asynchronously force state=IDLE, led_idx=0, offset=0 and latch counter=0.
REQ-034 During and after reset, o_sel=0, o_pix_valid=0, o_led_idx=0, o_latch=0, o_frame_done=0 and o_busy=0.
REQ-035 Reset asserted mid-SEND or mid-LATCH SHALL abandon the frame with no o_frame_done pulse.
REQ-036 After reset release, no activity SHALL occur until i_start.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding, the SEL_WIDTH=2 constant and the WIDTH_MUX=24 pixel-width constant.
REQ-038 The latch timer SHALL be a sub-module ws2812_latch_timer with ports start, count and expired.
REQ-039 All outputs SHALL be registered or decoded directly from state registers, with no combinational path from inputs.

Verification
REQ-040 NUM_LEDS=8, offset 0, i_pix_ready held at 1, one i_start pulse -> 8 consecutive valid cycles with o_sel=0,1,2,3,0,1,2,3 and o_led_idx=0..7.
REQ-041 i_pix_ready toggled 1/0 per cycle -> each o_sel value held until accepted; exactly 8 transfers occur.
REQ-042 i_ser_busy kept 1 for 20 cycles after the last transfer -> o_latch rises only after i_ser_busy falls, stays 1 for exactly RESET_CYCLES (5000) cycles, then one o_frame_done pulse.
REQ-043 i_continuous=1, i_rotate=1, 5 frames -> the first o_sel per frame is 0,1,2,3,0.
REQ-044 i_abort at led_idx=3 -> o_pix_valid drops next cycle, LATCH runs in full, o_frame_done pulses, FSM returns to IDLE, offset unchanged.
REQ-045 i_rst asserted at LATCH count 100 -> all outputs are 0 immediately; a following i_start begins at led_idx 0 with o_sel=0.
